flu_transformer_down: RTL



---
 rtl/flu_transformer_pkg.sv | 23 ++
 rtl/flu_seg_map.sv | 52 +++++
 rtl/flu_transformer_down.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/flu_transformer_pkg.sv
// FLU down-transformer shared package.
// Width helper, default geometry and FSM state encoding.
package flu_transformer_pkg;

  function automatic int log2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  localparam int DEF_RX_W  = 512;
  localparam int DEF_TX_W  = 128;
  localparam int DEF_RATIO = DEF_RX_W / DEF_TX_W;

  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } state_t;

endpackage

// File: rtl/flu_seg_map.sv
// Per-segment valid/sop/eop map of one buffered wide FLU word.
// Walks segments in byte order tracking whether a packet is open.
module flu_seg_map
  import flu_transformer_pkg::*;
#(
  parameter int RATIO = DEF_RATIO,
  parameter int SOPW  = 3,
  parameter int EOPW  = 6
) (
  input  logic             sop,
  input  logic [SOPW-1:0]  sop_pos,
  input  logic             eop,
  input  logic [EOPW-1:0]  eop_pos,
  input  logic             in_packet,
  output logic [RATIO-1:0] seg_vld,
  output logic [RATIO-1:0] seg_sop,
  output logic [RATIO-1:0] seg_eop,
  output logic             in_packet_nxt
);

  localparam int LR = log2(RATIO);

  logic [LR-1:0]   sop_seg;
  logic [LR-1:0]   eop_seg;
  logic [EOPW-1:0] sop_byte;
  logic            ip;

  assign sop_seg  = sop_pos[SOPW-1 -: LR];
  assign eop_seg  = eop_pos[EOPW-1 -: LR];
  assign sop_byte = EOPW'(sop_pos) << (EOPW - SOPW);

  // Segment k is valid if a packet is open at its start or starts in it.
  always_comb begin
    ip      = in_packet;
    seg_vld = '0;
    seg_sop = '0;
    seg_eop = '0;
    for (int k = 0; k < RATIO; k++) begin
      seg_sop[k] = sop & (sop_seg == LR'(k));
      seg_eop[k] = eop & (eop_seg == LR'(k));
      seg_vld[k] = ip | seg_sop[k];
      if (seg_sop[k] && seg_eop[k])
        ip = (eop_pos < sop_byte);
      else if (seg_sop[k])
        ip = 1'b1;
      else if (seg_eop[k])
        ip = 1'b0;
    end
    in_packet_nxt = ip;
  end

endmodule

// File: rtl/flu_transformer_down.sv
// FLU downsizing transformer: one wide word in, up to RATIO
// narrow words out, empty segments skipped without a cycle.
module flu_transformer_down
  import flu_transformer_pkg::*;
#(
  parameter int RX_DATA_WIDTH    = 512,
  parameter int TX_DATA_WIDTH    = 128,
  parameter int RX_SOP_POS_WIDTH = 3,
  parameter int HEADER_WIDTH     = 16,
  parameter int CHANNEL_WIDTH    = 2,
  localparam int RATIO = RX_DATA_WIDTH / TX_DATA_WIDTH,
  localparam int LR = log2(RATIO),
  localparam int RX_EOP_POS_WIDTH = log2(RX_DATA_WIDTH / 8),
  localparam int TX_EOP_POS_WIDTH = log2(TX_DATA_WIDTH / 8),
  localparam int TSR = RX_SOP_POS_WIDTH - LR,
  localparam int TX_SOP_POS_WIDTH = (TSR > 0) ? TSR : 1
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic [RX_DATA_WIDTH-1:0]    RX_DATA,
  input  logic [RX_SOP_POS_WIDTH-1:0] RX_SOP_POS,
  input  logic [RX_EOP_POS_WIDTH-1:0] RX_EOP_POS,
  input  logic                        RX_SOP,
  input  logic                        RX_EOP,
  input  logic [HEADER_WIDTH-1:0]     RX_HEADER,
  input  logic [CHANNEL_WIDTH-1:0]    RX_CHANNEL,
  input  logic                        RX_SRC_RDY,
  output logic                        RX_DST_RDY,
  output logic [TX_DATA_WIDTH-1:0]    TX_DATA,
  output logic [TX_SOP_POS_WIDTH-1:0] TX_SOP_POS,
  output logic [TX_EOP_POS_WIDTH-1:0] TX_EOP_POS,
  output logic                        TX_SOP,
  output logic                        TX_EOP,
  output logic [HEADER_WIDTH-1:0]     TX_HEADER,
  output logic [CHANNEL_WIDTH-1:0]    TX_CHANNEL,
  output logic                        TX_SRC_RDY,
  input  logic                        TX_DST_RDY
);

  state_t state, state_n;

  logic                        rdy_en;
  logic [RX_DATA_WIDTH-1:0]    bdata;
  logic                        bsop, beop;
  logic [RX_SOP_POS_WIDTH-1:0] bsop_pos;
  logic [RX_EOP_POS_WIDTH-1:0] beop_pos;
  logic [HEADER_WIDTH-1:0]     bhdr;
  logic [CHANNEL_WIDTH-1:0]    bchn;
  logic [RATIO-1:0]            done;
  logic                        in_pkt;

  logic [RATIO-1:0] seg_vld, seg_sop, seg_eop;
  logic [RATIO-1:0] rem, cur;
  logic             in_pkt_nxt;
  logic             has, last;
  logic             tx_fire, rx_fire, word_end;

  flu_seg_map #(
    .RATIO (RATIO),
    .SOPW  (RX_SOP_POS_WIDTH),
    .EOPW  (RX_EOP_POS_WIDTH)
  ) u_map (
    .sop           (bsop),
    .sop_pos       (bsop_pos),
    .eop           (beop),
    .eop_pos       (beop_pos),
    .in_packet     (in_pkt),
    .seg_vld       (seg_vld),
    .seg_sop       (seg_sop),
    .seg_eop       (seg_eop),
    .in_packet_nxt (in_pkt_nxt)
  );

  assign rem = (state == ST_SEND) ? (seg_vld & ~done) : '0;
  assign cur = rem & (~rem + RATIO'(1));
  assign has = |rem;
  assign last = ~|(rem & ~cur);
  assign tx_fire = has & TX_DST_RDY;
  assign word_end = (state == ST_SEND) & (~has | (tx_fire & last));

  assign RX_DST_RDY = rdy_en & ((state == ST_IDLE) | word_end);
  assign rx_fire = RX_SRC_RDY & RX_DST_RDY;

  // Next state: load on RX transfer, return idle after the last segment.
  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE: if (rx_fire) state_n = ST_SEND;
      ST_SEND: if (word_end && !rx_fire) state_n = ST_IDLE;
    endcase
  end

  // State register; RX ready is held low until the first cycle after reset.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state  <= ST_IDLE;
      rdy_en <= 1'b0;
    end else begin
      state  <= state_n;
      rdy_en <= 1'b1;
    end
  end

  // Input word buffer and per-segment emitted mask.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      bdata    <= '0;
      bsop     <= 1'b0;
      beop     <= 1'b0;
      bsop_pos <= '0;
      beop_pos <= '0;
      bhdr     <= '0;
      bchn     <= '0;
      done     <= '0;
    end else if (rx_fire) begin
      bdata    <= RX_DATA;
      bsop     <= RX_SOP;
      beop     <= RX_EOP;
      bsop_pos <= RX_SOP_POS;
      beop_pos <= RX_EOP_POS;
      bhdr     <= RX_HEADER;
      bchn     <= RX_CHANNEL;
      done     <= '0;
    end else if (tx_fire) begin
      done     <= done | cur;
    end
  end

  // Packet-open flag advances once the whole buffered word is out.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)
      in_pkt <= 1'b0;
    else if (word_end)
      in_pkt <= in_pkt_nxt;
  end

  // Narrow data mux on the one-hot current segment.
  always_comb begin
    TX_DATA = '0;
    for (int k = 0; k < RATIO; k++) begin
      if (cur[k]) TX_DATA = bdata[k*TX_DATA_WIDTH +: TX_DATA_WIDTH];
    end
  end

  assign TX_SRC_RDY = has;
  assign TX_SOP     = |(cur & seg_sop);
  assign TX_EOP     = |(cur & seg_eop);
  assign TX_EOP_POS = beop_pos[TX_EOP_POS_WIDTH-1:0];
  assign TX_HEADER  = bhdr;
  assign TX_CHANNEL = bchn;

  generate
    if (TSR > 0) begin : g_sp
      assign TX_SOP_POS = bsop_pos[TX_SOP_POS_WIDTH-1:0];
    end else begin : g_sp0
      assign TX_SOP_POS = '0;
    end
  endgenerate

endmodule
